// File: rtl/chaos_keystream_gen.sv
// chaos_keystream_gen: turns a stream of 33-bit chev3D_map samples into keystream bytes.
//
// After start is accepted, the first SKIP samples are discarded as warm-up; the next len samples
// are each folded to one byte (XOR of the four data bytes and the top bit) and pushed into a
// DEPTH-entry first-word-fall-through FIFO that the consumer drains via key_valid/key_ready.
//
// Parameters
//   SKIP  - warm-up samples discarded after start (0..65535)
//   DEPTH - output FIFO depth in bytes (power of two, >= 2)
// Ports
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   start     - one-cycle run request, honoured only when idle
//   len       - bytes to produce, sampled with start
//   xtn       - map sample
//   xtn_valid - xtn is valid
//   xtn_ready - sample accepted when xtn_valid && xtn_ready
//   key_byte  - FIFO head byte
//   key_valid - FIFO non-empty
//   key_ready - consumer accept; pop when key_valid && key_ready
//   busy      - run in progress (state not idle)
//   done      - one-cycle pulse the cycle after the last byte of a run is pushed
module chaos_keystream_gen #(
    parameter int unsigned SKIP  = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] len,
    input  logic [32:0] xtn,
    input  logic        xtn_valid,
    output logic        xtn_ready,
    output logic [7:0]  key_byte,
    output logic        key_valid,
    input  logic        key_ready,
    output logic        busy,
    output logic        done
);

    localparam int unsigned PtrW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt  = CntW'(DEPTH);
    localparam logic [15:0]     SkipInit = 16'(SKIP);

    typedef enum logic [1:0] {
        StIdle,
        StWarmup,
        StRun
    } state_e;

    state_e          state_q;
    logic [15:0]     skip_cnt_q;
    logic [15:0]     rem_q;
    logic            done_q;

    logic [7:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;

    logic            full;
    logic            empty;
    logic            xfer;
    logic            push;
    logic            pop;
    logic [7:0]      fold_byte;

    function automatic logic [7:0] fold(input logic [32:0] s);
        return s[7:0] ^ s[15:8] ^ s[23:16] ^ s[31:24] ^ {7'b0, s[32]};
    endfunction

    // Handshake decode. xtn_ready looks only at full, so a pop in the same
    // cycle never opens a slot for a push until the following cycle.
    always_comb begin
        full  = (count_q == FullCnt);
        empty = (count_q == '0);
        case (state_q)
            StWarmup: xtn_ready = 1'b1;
            StRun:    xtn_ready = !full;
            default:  xtn_ready = 1'b0;
        endcase
        xfer      = xtn_valid && xtn_ready;
        push      = xfer && (state_q == StRun);
        pop       = !empty && key_ready;
        fold_byte = fold(xtn);
    end

    // Control FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            skip_cnt_q <= '0;
            rem_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (len == '0) begin
                            // Empty run: report completion without leaving idle.
                            done_q <= 1'b1;
                        end else begin
                            rem_q <= len;
                            if (SKIP == 0) begin
                                state_q <= StRun;
                            end else begin
                                state_q    <= StWarmup;
                                skip_cnt_q <= SkipInit;
                            end
                        end
                    end
                end
                StWarmup: begin
                    if (xfer) begin
                        skip_cnt_q <= skip_cnt_q - 16'd1;
                        if (skip_cnt_q == 16'd1) begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (xfer) begin
                        rem_q <= rem_q - 16'd1;
                        if (rem_q == 16'd1) begin
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // FIFO bookkeeping; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; contents are meaningless until count_q says otherwise.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= fold_byte;
        end
    end

    assign key_byte  = mem_q[rd_ptr_q];
    assign key_valid = !empty;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;

endmodule

// File: tb/tb_chaos_keystream_gen.sv
// Testbench for chaos_keystream_gen. Two instances: "a" with SKIP=2 and "b" with SKIP=0,
// both DEPTH=8. Expected bytes are queued per instance when stimulus is issued; a monitor per
// instance pops and compares on every key_valid && key_ready handshake.
module tb_chaos_keystream_gen;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_start, a_xtn_valid, a_xtn_ready, a_key_valid, a_key_ready;
    logic        a_busy, a_done;
    logic [15:0] a_len;
    logic [32:0] a_xtn;
    logic [7:0]  a_key_byte;

    logic        b_rst, b_start, b_xtn_valid, b_xtn_ready, b_key_valid, b_key_ready;
    logic        b_busy, b_done;
    logic [15:0] b_len;
    logic [32:0] b_xtn;
    logic [7:0]  b_key_byte;

    chaos_keystream_gen #(.SKIP(2), .DEPTH(DEPTH)) u_dut_a (
        .clk       (clk),
        .rst       (a_rst),
        .start     (a_start),
        .len       (a_len),
        .xtn       (a_xtn),
        .xtn_valid (a_xtn_valid),
        .xtn_ready (a_xtn_ready),
        .key_byte  (a_key_byte),
        .key_valid (a_key_valid),
        .key_ready (a_key_ready),
        .busy      (a_busy),
        .done      (a_done)
    );

    chaos_keystream_gen #(.SKIP(0), .DEPTH(DEPTH)) u_dut_b (
        .clk       (clk),
        .rst       (b_rst),
        .start     (b_start),
        .len       (b_len),
        .xtn       (b_xtn),
        .xtn_valid (b_xtn_valid),
        .xtn_ready (b_xtn_ready),
        .key_byte  (b_key_byte),
        .key_valid (b_key_valid),
        .key_ready (b_key_ready),
        .busy      (b_busy),
        .done      (b_done)
    );

    int          checks = 0;
    int          failures = 0;
    int          a_done_cnt = 0;
    int          b_done_cnt = 0;
    int          d0;
    int          cons_guard;
    bit          prod_done;
    logic [7:0]  exp_a[$];
    logic [7:0]  exp_b[$];
    logic [7:0]  a_exp, b_exp;
    logic [32:0] rnd_sample;

    function automatic logic [7:0] model_fold(input logic [32:0] s);
        logic [7:0] r;
        r = {7'b0, s[32]};
        for (int i = 0; i < 4; i++) r = r ^ s[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [32:0] bsamp(input int i);
        return 33'h0_1357_9BDF + 33'(i) * 33'h1_0304_0506;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [32:0] s);
        int n;
        n = 0;
        a_xtn = s;
        a_xtn_valid = 1'b1;
        @(negedge clk);
        while (!a_xtn_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!a_xtn_ready) begin
            checks++;
            failures++;
            $display("FAIL a_xtn_ready_timeout: got %0b required 1", a_xtn_ready);
        end
        @(posedge clk);
        #1;
        a_xtn_valid = 1'b0;
    endtask

    task automatic send_b(input logic [32:0] s);
        int n;
        n = 0;
        b_xtn = s;
        b_xtn_valid = 1'b1;
        @(negedge clk);
        while (!b_xtn_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!b_xtn_ready) begin
            checks++;
            failures++;
            $display("FAIL b_xtn_ready_timeout: got %0b required 1", b_xtn_ready);
        end
        @(posedge clk);
        #1;
        b_xtn_valid = 1'b0;
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        if (a_done === 1'b1) a_done_cnt++;
        if (!a_rst && a_key_valid && a_key_ready) begin
            checks++;
            if (exp_a.size() == 0) begin
                failures++;
                $display("FAIL a_key_byte: got %02h required no byte", a_key_byte);
            end else begin
                a_exp = exp_a.pop_front();
                if (a_key_byte !== a_exp) begin
                    failures++;
                    $display("FAIL a_key_byte: got %02h required %02h", a_key_byte, a_exp);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (b_done === 1'b1) b_done_cnt++;
        if (!b_rst && b_key_valid && b_key_ready) begin
            checks++;
            if (exp_b.size() == 0) begin
                failures++;
                $display("FAIL b_key_byte: got %02h required no byte", b_key_byte);
            end else begin
                b_exp = exp_b.pop_front();
                if (b_key_byte !== b_exp) begin
                    failures++;
                    $display("FAIL b_key_byte: got %02h required %02h", b_key_byte, b_exp);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        a_rst = 1'b1; a_start = 1'b0; a_len = '0; a_xtn = '0; a_xtn_valid = 1'b0;
        a_key_ready = 1'b0;
        b_rst = 1'b1; b_start = 1'b0; b_len = '0; b_xtn = '0; b_xtn_valid = 1'b0;
        b_key_ready = 1'b0;
        prod_done = 1'b0;
        tick();
        tick();
        a_rst = 1'b0;
        b_rst = 1'b0;

        // Reset state
        check("rst_a_key_valid", 32'(a_key_valid), 0);
        check("rst_a_xtn_ready", 32'(a_xtn_ready), 0);
        check("rst_a_busy", 32'(a_busy), 0);
        check("rst_a_done", 32'(a_done), 0);
        check("rst_b_key_valid", 32'(b_key_valid), 0);
        check("rst_b_busy", 32'(b_busy), 0);

        // SKIP=2, len=3: two warm-up samples dropped, bytes 7C 40 09
        a_key_ready = 1'b1;
        a_len = 16'd3;
        a_start = 1'b1;
        d0 = a_done_cnt;
        tick();
        a_start = 1'b0;
        check("warm_busy", 32'(a_busy), 1);
        check("warm_xtn_ready", 32'(a_xtn_ready), 1);
        exp_a.push_back(8'h7C);
        exp_a.push_back(8'h40);
        exp_a.push_back(8'h09);
        send_a(33'h0_0000_007C);
        send_a(33'h0_0000_04DD);
        check("warm_no_push", 32'(a_key_valid), 0);
        send_a(33'h0_0000_007C);
        check("push_latency", 32'(a_key_valid), 1);
        send_a(33'h0_4000_0000);
        check("run_busy_mid", 32'(a_busy), 1);
        send_a(33'h1_1234_5678);
        check("end_busy", 32'(a_busy), 0);
        check("end_done", 32'(a_done), 1);
        tick();
        check("end_done_fall", 32'(a_done), 0);
        tick();
        tick();
        check("dir_drain", 32'(exp_a.size()), 0);
        check("dir_done_once", 32'(a_done_cnt - d0), 1);

        // len=0: done one cycle after start, never leaves idle
        a_len = 16'd0;
        a_start = 1'b1;
        d0 = a_done_cnt;
        tick();
        a_start = 1'b0;
        check("len0_done", 32'(a_done), 1);
        check("len0_busy", 32'(a_busy), 0);
        check("len0_xtn_ready", 32'(a_xtn_ready), 0);
        tick();
        check("len0_done_fall", 32'(a_done), 0);
        check("len0_done_once", 32'(a_done_cnt - d0), 1);

        // start while busy is ignored
        a_len = 16'd2;
        a_start = 1'b1;
        d0 = a_done_cnt;
        tick();
        a_len = 16'd5;
        tick();
        a_start = 1'b0;
        exp_a.push_back(8'h04);
        exp_a.push_back(8'h01);
        send_a(33'h1_0000_0000);
        send_a(33'h0_0000_0011);
        send_a(33'h0_0102_0304);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        send_a(33'h1_FF00_FF00);
        check("restart_busy", 32'(a_busy), 0);
        check("restart_done", 32'(a_done), 1);
        tick();
        check("restart_xtn_ready", 32'(a_xtn_ready), 0);
        tick();
        check("restart_drain", 32'(exp_a.size()), 0);
        check("restart_done_once", 32'(a_done_cnt - d0), 1);

        // Reset mid-run with 3 bytes buffered
        a_key_ready = 1'b0;
        a_len = 16'd10;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        send_a(33'h0_0000_0001);
        send_a(33'h0_0000_0002);
        send_a(33'h0_0000_00A1);
        send_a(33'h0_0000_00A2);
        send_a(33'h0_0000_00A3);
        check("abort_buffered", 32'(a_key_valid), 1);
        d0 = a_done_cnt;
        a_rst = 1'b1;
        a_start = 1'b1;
        tick();
        a_rst = 1'b0;
        a_start = 1'b0;
        check("abort_key_valid", 32'(a_key_valid), 0);
        check("abort_busy", 32'(a_busy), 0);
        check("abort_xtn_ready", 32'(a_xtn_ready), 0);
        a_key_ready = 1'b1;
        a_xtn_valid = 1'b1;
        repeat (4) tick();
        a_xtn_valid = 1'b0;
        check("abort_no_done", 32'(a_done_cnt - d0), 0);
        check("abort_still_empty", 32'(a_key_valid), 0);

        // SKIP=0, len=DEPTH+2, full back-pressure
        b_key_ready = 1'b0;
        b_len = 16'(DEPTH + 2);
        b_start = 1'b1;
        d0 = b_done_cnt;
        tick();
        b_start = 1'b0;
        check("b_run_busy", 32'(b_busy), 1);
        check("b_run_ready", 32'(b_xtn_ready), 1);
        for (int i = 0; i < DEPTH + 2; i++) exp_b.push_back(model_fold(bsamp(i)));
        for (int i = 0; i < DEPTH; i++) send_b(bsamp(i));
        check("full_xtn_ready", 32'(b_xtn_ready), 0);
        check("full_key_valid", 32'(b_key_valid), 1);
        b_xtn = bsamp(DEPTH);
        b_xtn_valid = 1'b1;
        b_key_ready = 1'b1;
        tick();
        b_key_ready = 1'b0;
        check("pop_full_no_push", 32'(b_xtn_ready), 1);
        tick();
        b_xtn_valid = 1'b0;
        check("refill_full", 32'(b_xtn_ready), 0);
        b_key_ready = 1'b1;
        send_b(bsamp(DEPTH + 1));
        check("b_end_done", 32'(b_done), 1);
        check("b_end_busy", 32'(b_busy), 0);
        repeat (DEPTH + 4) tick();
        check("b_drain", 32'(exp_b.size()), 0);
        check("b_done_once", 32'(b_done_cnt - d0), 1);

        // 1000-byte run with random valid/ready
        a_key_ready = 1'b0;
        a_len = 16'd1000;
        a_start = 1'b1;
        d0 = a_done_cnt;
        tick();
        a_start = 1'b0;
        fork
            begin
                for (int i = 0; i < 1002; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    rnd_sample = {1'($urandom_range(0, 1)), 32'($urandom())};
                    if (i >= 2) exp_a.push_back(model_fold(rnd_sample));
                    send_a(rnd_sample);
                end
                prod_done = 1'b1;
            end
            begin
                cons_guard = 0;
                while (!(prod_done && exp_a.size() == 0) && cons_guard < 20000) begin
                    tick();
                    a_key_ready = 1'($urandom_range(0, 1));
                    cons_guard++;
                end
                a_key_ready = 1'b1;
            end
        join
        tick();
        check("rand_drain", 32'(exp_a.size()), 0);
        check("rand_busy", 32'(a_busy), 0);
        check("rand_key_valid", 32'(a_key_valid), 0);
        check("rand_done_once", 32'(a_done_cnt - d0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chaos_keystream_gen.md
CHAOS_KEYSTREAM_GEN -- requirements
Module: chaos_keystream_gen

Interface
REQ-001 SHALL have parameter SKIP, default 16, the number of warm-up map samples discarded after start (0..65535).
REQ-002 SHALL have parameter DEPTH, default 8, the output FIFO depth in bytes (power of two, >=2).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit, the reset: synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit, a one-cycle request to begin a keystream run; honoured only in IDLE.
REQ-006 SHALL have port len, input, 16 bits, the number of keystream bytes to produce; sampled when start is accepted.
REQ-007 SHALL have port xtn, input, 33 bits, a chev3D_map output sample.
REQ-008 SHALL have port xtn_valid, input, 1 bit, which marks xtn as valid.
REQ-009 SHALL have port xtn_ready, output, 1 bit, which accepts a sample; transfer occurs when xtn_valid && xtn_ready.
REQ-010 SHALL have port key_byte, output, 8 bits, the keystream byte at the FIFO head.
REQ-011 SHALL have port key_valid, output, 1 bit, asserted when the FIFO is non-empty.
REQ-012 SHALL have port key_ready, input, 1 bit, the consumer accept; a pop occurs when key_valid && key_ready.
REQ-013 SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-014 SHALL have port done, output, 1 bit, a one-cycle pulse in the cycle after the last byte of a run is pushed.

Function
REQ-015 SHALL implement the FSM states IDLE, WARMUP and RUN.
REQ-016 SHALL transition on start in IDLE as follows: len==0 -> stay in IDLE and pulse done next cycle; else if SKIP==0 -> RUN; otherwise -> WARMUP with skip_cnt=SKIP.
REQ-017 SHALL, in WARMUP, drive xtn_ready=1; each transfer decrements skip_cnt; the transfer that takes skip_cnt to 0 moves the state to RUN; no WARMUP sample is pushed.
REQ-018 SHALL, in RUN, drive xtn_ready=!full; each transfer pushes fold(xtn) and decrements remaining count rem (loaded with len).
REQ-019 SHALL, on the transfer taking rem to 0, move the state to IDLE; done pulses in the following cycle.
REQ-020 SHALL drive xtn_ready=0 in IDLE.
REQ-021 SHALL compute fold(xtn) = xtn[7:0]^xtn[15:8]^xtn[23:16]^xtn[31:24]^{7'b0,xtn[32]}.
REQ-022 SHALL implement a FIFO with DEPTH entries, first-word-fall-through: key_byte shows the head entry combinationally from registered storage.
REQ-023 SHALL make a pushed byte visible on key_valid/key_byte in the cycle after its transfer, giving 1-cycle latency.
REQ-024 SHALL decide xtn_ready on full only, so a simultaneous pop while full does not allow a push in that cycle.
REQ-025 SHALL allow a simultaneous push and pop when neither full nor empty; the occupancy is then unchanged.
REQ-026 SHALL wrap the FIFO pointers modulo DEPTH; full/empty are derived from an occupancy counter of width clog2(DEPTH)+1.
REQ-027 SHALL leave key_byte undefined but stable while key_valid=0, and keep it stable while key_valid && !key_ready.
REQ-028 SHALL ignore start while busy.
REQ-029 SHALL continue to drain the FIFO via key_ready after the return to IDLE.
REQ-030 SHALL ignore xtn_valid while xtn_ready=0, with no side effects.

Reset
REQ-031 SHALL, with rst high at a clock edge, set the state to IDLE, skip_cnt=0, rem=0, FIFO pointers and occupancy to 0, key_valid=0, xtn_ready=0, busy=0, done=0.
REQ-032 SHALL abort a run on reset mid-run; FIFO contents are discarded and no done pulse is produced.
REQ-033 SHALL give rst priority over start in the same cycle.

Verification
REQ-034 SHALL cover: SKIP=2, len=3, xtn stream 0x7C, 0x4DD, 0x7C, 0x0_4000_0000, 0x1_1234_5678, with key_ready=1 -> the first two samples are dropped; key_byte sequence 0x7C, 0x40, 0x09; done pulses once; busy falls after the third push.
REQ-035 SHALL cover: SKIP=0, len=DEPTH+2, key_ready=0 -> after DEPTH pushes xtn_ready=0 and key_valid=1; then key_ready=1 for 1 cycle -> one pop and no push that cycle; xtn_ready=1 the next cycle.
REQ-036 SHALL cover: start with len=0 -> state stays IDLE, xtn_ready stays 0, and done pulses exactly one cycle after start.
REQ-037 SHALL cover: rst asserted during RUN with 3 bytes buffered -> the next cycle shows key_valid=0, busy=0, xtn_ready=0, and done never pulses.
REQ-038 SHALL cover: start asserted again while busy -> no effect on rem or state, and the byte count of the run is unchanged.
REQ-039 SHALL cover: random xtn_valid/key_ready toggling over 1000 bytes -> the output byte sequence equals the fold of accepted RUN samples in order, with no loss or duplication.
